// File: rtl/dual_port_ram_ctrl.sv
// dual_port_ram_ctrl: true dual-port synchronous memory with byte-lane
// writes, selectable same-port read-during-write, same-address write
// arbitration (port A wins overlapping lanes), and a clear engine that
// zeroes the array one word per cycle.
//
// Handshake: there is no valid/ready pair. A port acts on a rising edge
// when en_x=1; a write also needs wren_x=1. q_x is registered and valid
// from the cycle after the edge. busy=1 means the clear engine owns the
// array; user writes are dropped and q_a/q_b read 0 while it is high.
module dual_port_ram_ctrl #(
  parameter int DATA_W       = 24,
  parameter int LANE_W       = 8,
  parameter int ADDR_W       = 18,
  parameter int DEPTH        = 2**ADDR_W,
  parameter int RDW_NEW_DATA = 0
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       init_req,
  output logic                       busy,
  input  logic                       en_a,
  input  logic                       wren_a,
  input  logic [DATA_W/LANE_W-1:0]   be_a,
  input  logic [ADDR_W-1:0]          address_a,
  input  logic [DATA_W-1:0]          data_a,
  output logic [DATA_W-1:0]          q_a,
  input  logic                       en_b,
  input  logic                       wren_b,
  input  logic [DATA_W/LANE_W-1:0]   be_b,
  input  logic [ADDR_W-1:0]          address_b,
  input  logic [DATA_W-1:0]          data_b,
  output logic [DATA_W-1:0]          q_b,
  output logic                       collision,
  output logic                       fsm_state
);

  localparam int                LANES   = DATA_W / LANE_W;
  localparam logic [ADDR_W:0]   DEPTH_X = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST    = ADDR_W'(DEPTH - 1);

  typedef enum logic {S_IDLE = 1'b0, S_CLEAR = 1'b1} state_t;

  state_t            state;
  logic [ADDR_W-1:0] cnt;
  logic [DATA_W-1:0] mem [DEPTH];

  logic              in_a, in_b, wr_a, wr_b, same_wr;
  logic [DATA_W-1:0] mask_a, mask_b, old_a, old_b, rd_a, rd_b;

  // Debug view of the FSM: 1 while the clear engine runs.
  assign fsm_state = state;

  // Expand per-lane enables into a full-width bit mask.
  function automatic logic [DATA_W-1:0] lane_mask(input logic [LANES-1:0] be);
    logic [DATA_W-1:0] m;
    m = '0;
    for (int i = 0; i < LANES; i++) m[i*LANE_W +: LANE_W] = {LANE_W{be[i]}};
    return m;
  endfunction

  // Address decode, write qualification and the word each port would read.
  always_comb begin
    in_a    = ({1'b0, address_a} < DEPTH_X);
    in_b    = ({1'b0, address_b} < DEPTH_X);
    wr_a    = en_a && wren_a && in_a;
    wr_b    = en_b && wren_b && in_b;
    same_wr = wr_a && wr_b && (address_a == address_b);
    mask_a  = lane_mask(be_a);
    mask_b  = lane_mask(be_b);
    old_a   = '0;
    old_b   = '0;
    if (in_a) old_a = mem[address_a];
    if (in_b) old_b = mem[address_b];
    // Cross-port RDW always sees the old word; only a port's own write can
    // be forwarded, and only when new-data mode is selected.
    rd_a = old_a;
    rd_b = old_b;
    if (RDW_NEW_DATA != 0 && wr_a) rd_a = (old_a & ~mask_a) | (data_a & mask_a);
    if (RDW_NEW_DATA != 0 && wr_b) rd_b = (old_b & ~mask_b) | (data_b & mask_b);
  end

  // Clear-engine FSM; busy is registered alongside the state.
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= S_IDLE;
      cnt   <= '0;
      busy  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (init_req) begin
            state <= S_CLEAR;
            busy  <= 1'b1;
            cnt   <= '0;
          end
        end
        S_CLEAR: begin
          if (cnt == LAST) begin
            state <= S_IDLE;
            busy  <= 1'b0;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Array writes: clear engine, else per-lane user writes with A winning
  // lanes that both ports enable on the same address. No reset of contents.
  always_ff @(posedge clock) begin
    if (!reset) begin
      if (state == S_CLEAR) begin
        mem[cnt] <= '0;
      end else begin
        for (int i = 0; i < LANES; i++) begin
          if (wr_a && be_a[i])
            mem[address_a][i*LANE_W +: LANE_W] <= data_a[i*LANE_W +: LANE_W];
          if (wr_b && be_b[i] && !(same_wr && be_a[i]))
            mem[address_b][i*LANE_W +: LANE_W] <= data_b[i*LANE_W +: LANE_W];
        end
      end
    end
  end

  // Registered read data and collision flag. A dropped (out-of-range)
  // write cannot collide, so the flag needs both writes to be in range.
  always_ff @(posedge clock) begin
    if (reset) begin
      q_a       <= '0;
      q_b       <= '0;
      collision <= 1'b0;
    end else if (state == S_CLEAR) begin
      q_a       <= '0;
      q_b       <= '0;
      collision <= 1'b0;
    end else begin
      if (en_a) q_a <= rd_a;
      if (en_b) q_b <= rd_b;
      collision <= same_wr && (|(be_a & be_b));
    end
  end

endmodule

// File: doc/dual_port_ram_ctrl.md
Name: dual_port_ram_ctrl

Overview:
Parametrised true dual-port synchronous memory for the microarchitecture's main/data memory. Successor to the fixed 18-bit-address, 24-bit-data main memory, adding:
- per-port enables and byte-lane write enables
- selectable read-during-write behaviour
- deterministic same-address write arbitration with a collision flag
- a hardware clear engine that zeroes the array on request
Sits between the CPU datapath (port A) and the DMA/video side (port B).

Parameters:
DATA_W, 24, word width in bits
LANE_W, 8, write-lane width; DATA_W must be a multiple of LANE_W
ADDR_W, 18, address width
DEPTH, 2**ADDR_W, number of implemented words; DEPTH <= 2**ADDR_W
RDW_NEW_DATA, 0, same-port read-during-write: 0 returns old data, 1 returns newly written data

Ports:
clock  in  1  single clock, all activity on rising edge
reset  in  1  synchronous, active-high
init_req  in  1  pulse in IDLE starts the clear sequence
busy  out  1  high while clearing
en_a  in  1  port A enable
wren_a  in  1  port A write
be_a  in  DATA_W/LANE_W  port A lane enables
address_a  in  ADDR_W  port A address
data_a  in  DATA_W  port A write data
q_a  out  DATA_W  port A read data (registered)
en_b, wren_b, be_b, address_b, data_b, q_b  same as port A, for port B
collision  out  1  registered same-address write-write flag

Behaviour:
- Reset state: q_a=0, q_b=0, collision=0, busy=0, FSM=IDLE, clear counter=0. Array contents are NOT modified by reset.
- Read latency is 1 cycle. At rising edge k, when en_x=1, q_x <= mem[address_x] as of before edge k's writes, except in the same-port RDW case below. q_x is valid after edge k.
- When en_x=0: q_x holds its value and no write occurs on that port.
- Write occurs at edge k when en_x=1 and wren_x=1. Only lanes with be_x[i]=1 are updated; lane i = bits [i*LANE_W +: LANE_W].
- Same-port read-during-write:
  - RDW_NEW_DATA=0: q_x = old word.
  - RDW_NEW_DATA=1: q_x = old word with enabled lanes replaced by data_x.
- Cross-port read-during-write (one port writes, the other reads the same address): the reader always gets the old word.
- Same-address write-write (both ports write, address_a==address_b):
  - Per lane, A wins where both be bits are set; each port's exclusively enabled lanes are written normally.
  - collision=1 for exactly the cycle after the edge, only if be_a & be_b != 0; otherwise collision=0.
- Out-of-range address (address_x >= DEPTH): write dropped; read gives q_x=0.
- FSM states:
  - IDLE to CLEAR when init_req=1 at an edge. busy=1 from the next cycle.
  - CLEAR writes 0 to address cnt, cnt increments 0..DEPTH-1, one word per cycle.
  - After writing DEPTH-1, go to IDLE; busy=0 in the cycle after the last write. Total busy = DEPTH cycles.
  - In CLEAR, user writes on both ports are ignored, q_a and q_b are forced to 0, and collision stays 0.
  - init_req while in CLEAR is ignored.
- Reset mid-CLEAR: abort to IDLE next cycle. Words already cleared stay 0; remaining words keep their old contents.
- Reset has priority over every other input in the same cycle.

Test Plan:
Benches use DATA_W=24, LANE_W=8, ADDR_W=4, DEPTH=12.
1. Write A addr 0 = 0x0000FF (be=111), next cycle read A addr 0 -> q_a=0x0000FF one cycle later; with en_a=0 afterwards, q_a holds 0x0000FF while address changes.
2. mem[3]=0x123456; A writes 0xAABBCC be=010 to addr 3 while reading it -> RDW_NEW_DATA=0: q_a=0x123456, then mem[3]=0x12BB56. Repeat with RDW_NEW_DATA=1 -> q_a=0x12BB56.
3. Same edge: A writes 0x111111 be=011, B writes 0x222222 be=110, both to addr 5 -> mem[5]=0x221111, collision=1 for one cycle. With be_a=001, be_b=100 -> mem[5]=0x220011 (from prior 0x000000), collision=0.
4. A writes 0xFFFF00 to addr 7 while B reads addr 7 -> q_b=old value; B re-reads next cycle -> q_b=0xFFFF00.
5. Address 13 (>= DEPTH): write 0x00ABCD, then read -> q=0, and no in-range word changed.
6. Fill all 12 words with nonzero data, pulse init_req -> busy high 12 cycles, q=0 and writes ignored meanwhile, then all words read 0. Repeat with reset asserted after 5 clear cycles -> busy=0 next cycle, words 0-4 read 0, words 5-11 keep their data.
